// File: rtl/mxv_pop_sched.sv
// Pop-side scheduler for the matrix-vector multiply datapath: pops the row/vector
// FIFOs column by column, gates the row accumulators, then hands out row results.
module mxv_pop_sched #(
  parameter int MAX_N = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [3:0]       n_i,
  input  logic             abort_i,
  input  logic [MAX_N-1:0] fifo_empty_i,
  input  logic             vec_empty_i,
  input  logic             out_ready_i,
  output logic             pop_o,
  output logic             mac_clear_o,
  output logic             mac_en_o,
  output logic             out_valid_o,
  output logic [2:0]       out_row_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_POP,
    S_DRAIN,
    S_OUT
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       n_q, n_d;
  logic [2:0]       col_q, col_d;
  logic [2:0]       row_q, row_d;
  logic             mac_en_q;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [MAX_N-1:0] row_mask;
  logic [3:0]       last_idx;
  logic             stall;
  logic             pop;
  logic             n_legal;

  // Only the rows that belong to the current matrix may hold off a pop.
  always_comb begin
    for (int i = 0; i < MAX_N; i++) begin
      row_mask[i] = (i < int'(n_q));
    end
  end

  assign last_idx = n_q - 4'd1;
  assign stall    = vec_empty_i | (|(fifo_empty_i & row_mask));
  assign n_legal  = (n_i != 4'd0) && (int'(n_i) <= MAX_N);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    n_d     = n_q;
    col_d   = col_q;
    row_d   = row_q;
    pop     = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (abort_i) begin
      state_d = S_IDLE;
      col_d   = 3'd0;
      row_d   = 3'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (n_legal) begin
              n_d     = n_i;
              state_d = S_CLEAR;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_CLEAR: begin
          col_d   = 3'd0;
          state_d = S_POP;
        end
        S_POP: begin
          if (!stall) begin
            pop = 1'b1;
            if (col_q == last_idx[2:0]) begin
              state_d = S_DRAIN;
            end else begin
              col_d = col_q + 3'd1;
            end
          end
        end
        S_DRAIN: begin
          row_d   = 3'd0;
          state_d = S_OUT;
        end
        S_OUT: begin
          if (out_ready_i) begin
            if (row_q == last_idx[2:0]) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              row_d = row_q + 3'd1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      n_q      <= 4'd0;
      col_q    <= 3'd0;
      row_q    <= 3'd0;
      mac_en_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      n_q      <= n_d;
      col_q    <= col_d;
      row_q    <= row_d;
      mac_en_q <= pop;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // mac_en trails pop by one cycle to line up with the FIFO read latency.
  assign pop_o       = pop;
  assign mac_en_o    = mac_en_q;
  assign mac_clear_o = (state_q == S_CLEAR);
  assign busy_o      = (state_q != S_IDLE);
  assign out_valid_o = (state_q == S_OUT);
  assign out_row_o   = (state_q == S_OUT) ? row_q : 3'd0;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_mxv_pop_sched.sv
// Self-checking bench for mxv_pop_sched: directed scenarios plus randomized runs
// compared cycle by cycle against a schedule computed from the operating rules.
module tb_mxv_pop_sched;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       start_i;
  logic [3:0] n_i;
  logic       abort_i;
  logic [7:0] fifo_empty_i;
  logic       vec_empty_i;
  logic       out_ready_i;
  logic       pop_o;
  logic       mac_clear_o;
  logic       mac_en_o;
  logic       out_valid_o;
  logic [2:0] out_row_o;
  logic       busy_o;
  logic       done_o;
  logic       err_o;

  int checks = 0;
  int errors = 0;

  // Per-cycle stimulus and expected outputs, indexed by cycle from start.
  bit       vec_e [256];
  bit [7:0] fe    [256];
  bit       rdy   [256];
  bit       e_pop [256];
  bit       e_clr [256];
  bit       e_men [256];
  bit       e_ov  [256];
  bit       e_busy[256];
  bit       e_done[256];
  int       e_row [256];

  mxv_pop_sched #(.MAX_N(8)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .start_i     (start_i),
    .n_i         (n_i),
    .abort_i     (abort_i),
    .fifo_empty_i(fifo_empty_i),
    .vec_empty_i (vec_empty_i),
    .out_ready_i (out_ready_i),
    .pop_o       (pop_o),
    .mac_clear_o (mac_clear_o),
    .mac_en_o    (mac_en_o),
    .out_valid_o (out_valid_o),
    .out_row_o   (out_row_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic idle_inputs();
    start_i      = 1'b0;
    n_i          = 4'd0;
    abort_i      = 1'b0;
    fifo_empty_i = 8'h00;
    vec_empty_i  = 1'b0;
    out_ready_i  = 1'b0;
  endtask

  task automatic fill_clean();
    for (int i = 0; i < 256; i++) begin
      vec_e[i] = 1'b0;
      fe[i]    = 8'h00;
      rdy[i]   = 1'b1;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 256; i++) begin
      vec_e[i] = (i < 100) && ($urandom_range(4, 0) == 0);
      fe[i]    = (i < 100) ? (8'($urandom) & 8'($urandom) & 8'($urandom) & 8'($urandom)) : 8'h00;
      rdy[i]   = (i >= 150) || ($urandom_range(9, 0) < 7);
    end
  endtask

  // Expected schedule: one clear cycle, then N successful pops in non-stalled
  // cycles, one drain cycle, then N results each consumed on a ready cycle.
  task automatic build_model(input int n, output int last);
    int c;
    int popped;
    int row;
    bit stall;
    for (int i = 0; i < 256; i++) begin
      e_pop[i] = 0; e_clr[i] = 0; e_men[i] = 0; e_ov[i] = 0;
      e_busy[i] = 0; e_done[i] = 0; e_row[i] = 0;
    end
    e_clr[1]  = 1;
    e_busy[1] = 1;
    c = 2;
    popped = 0;
    while (popped < n) begin
      e_busy[c] = 1;
      stall = vec_e[c] || ((int'(fe[c]) % (1 << n)) != 0);
      if (!stall) begin
        e_pop[c]     = 1;
        e_men[c + 1] = 1;
        popped++;
      end
      c++;
    end
    e_busy[c] = 1;
    c++;
    row = 0;
    while (row < n) begin
      e_busy[c] = 1;
      e_ov[c]   = 1;
      e_row[c]  = row;
      if (rdy[c]) row++;
      c++;
    end
    e_done[c] = 1;
    last = c;
  endtask

  // Runs one operation from cycle 0 (or cycle 1 when start was already given
  // in the previous run's done cycle) and compares every output every cycle.
  task automatic run_op(input int n, input bit started, input bit chain,
                        input int chain_n, input bit noise, output int dut_done);
    int last;
    logic [9:0] got;
    logic [9:0] exp_v;
    build_model(n, last);
    dut_done = -1;
    for (int c = (started ? 1 : 0); c <= last; c++) begin
      if (c == 0) begin
        start_i = 1'b1;
        n_i     = 4'(n);
      end else if (c == last) begin
        start_i = chain;
        n_i     = 4'(chain_n);
      end else begin
        start_i = noise && ($urandom_range(1, 0) == 1);
        n_i     = 4'($urandom);
      end
      abort_i      = 1'b0;
      vec_empty_i  = vec_e[c];
      fifo_empty_i = fe[c];
      out_ready_i  = rdy[c];
      @(negedge clk_i);
      got   = {pop_o, mac_clear_o, mac_en_o, out_valid_o, out_row_o, busy_o, done_o, err_o};
      exp_v = {e_pop[c], e_clr[c], e_men[c], e_ov[c], 3'(e_row[c]), e_busy[c], e_done[c], 1'b0};
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL run n=%0d cycle %0d {pop,clr,men,ov,row,busy,done,err} got %b expected %b",
                 n, c, got, exp_v);
      end
      if (done_o === 1'b1) dut_done = c;
      @(posedge clk_i);
      #1;
    end
    if (!chain) idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_i = 1'b1;
    #2;
    checks++;
    if ({pop_o, mac_clear_o, mac_en_o, out_valid_o, out_row_o, busy_o, done_o, err_o} !== 10'd0) begin
      errors++;
      $display("FAIL reset_state got %b expected 0",
               {pop_o, mac_clear_o, mac_en_o, out_valid_o, out_row_o, busy_o, done_o, err_o});
    end
    #5 reset_i = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_n3_basic();
    int d;
    fill_clean();
    run_op(3, 0, 0, 0, 0, d);
    checks++;
    if (d !== 9) begin errors++; $display("FAIL n3_done_cycle got %0d expected 9", d); end
  endtask

  task automatic test_n8_stall();
    int d;
    fill_clean();
    vec_e[4] = 1'b1;
    vec_e[5] = 1'b1;
    run_op(8, 0, 0, 0, 0, d);
    checks++;
    if (d !== 21) begin errors++; $display("FAIL n8_stall_done_cycle got %0d expected 21", d); end
  endtask

  task automatic test_unused_flag();
    int d;
    fill_clean();
    for (int i = 0; i < 256; i++) fe[i] = 8'h20;
    run_op(2, 0, 0, 0, 0, d);
    checks++;
    if (d !== 7) begin errors++; $display("FAIL unused_flag_done_cycle got %0d expected 7", d); end
  endtask

  task automatic test_backpressure();
    int d;
    fill_clean();
    rdy[7] = 1'b0;
    rdy[8] = 1'b0;
    rdy[9] = 1'b0;
    run_op(4, 0, 0, 0, 0, d);
    checks++;
    if (d !== 14) begin errors++; $display("FAIL backpressure_done_cycle got %0d expected 14", d); end
  endtask

  task automatic test_illegal_n();
    int bad [3] = '{0, 9, 15};
    foreach (bad[k]) begin
      idle_inputs();
      out_ready_i = 1'b1;
      start_i = 1'b1;
      n_i     = 4'(bad[k]);
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      for (int c = 1; c <= 4; c++) begin
        @(negedge clk_i);
        checks++;
        if ({err_o, busy_o, pop_o, mac_clear_o} !== {(c == 1), 3'b000}) begin
          errors++;
          $display("FAIL illegal_n N=%0d cycle %0d {err,busy,pop,clr} got %b expected %b",
                   bad[k], c, {err_o, busy_o, pop_o, mac_clear_o}, {(c == 1), 3'b000});
        end
        @(posedge clk_i);
        #1;
      end
    end
    idle_inputs();
  endtask

  task automatic test_abort();
    idle_inputs();
    out_ready_i = 1'b1;
    for (int c = 0; c <= 15; c++) begin
      start_i = (c == 0);
      n_i     = 4'd5;
      abort_i = (c == 3);
      @(negedge clk_i);
      checks++;
      if (c == 2) begin
        if ({pop_o, mac_en_o, busy_o} !== 3'b101) begin
          errors++; $display("FAIL abort_pre cycle 2 {pop,men,busy} got %b expected 101", {pop_o, mac_en_o, busy_o});
        end
      end else if (c == 3) begin
        if ({pop_o, mac_en_o, busy_o} !== 3'b011) begin
          errors++; $display("FAIL abort_cycle {pop,men,busy} got %b expected 011", {pop_o, mac_en_o, busy_o});
        end
      end else if (c >= 4) begin
        if ({pop_o, mac_en_o, busy_o, done_o, out_valid_o} !== 5'b0) begin
          errors++;
          $display("FAIL abort_after cycle %0d {pop,men,busy,done,ov} got %b expected 00000",
                   c, {pop_o, mac_en_o, busy_o, done_o, out_valid_o});
        end
      end else begin
        if (busy_o !== (c == 1)) begin
          errors++; $display("FAIL abort_start cycle %0d busy got %b expected %b", c, busy_o, (c == 1));
        end
      end
      @(posedge clk_i);
      #1;
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    idle_inputs();
    for (int c = 0; c <= 6; c++) begin
      start_i = (c == 0);
      n_i     = 4'd2;
      @(negedge clk_i);
      if (c == 6) begin
        checks++;
        if (out_valid_o !== 1'b1) begin
          errors++; $display("FAIL async_pre out_valid got %b expected 1", out_valid_o);
        end
        #2 reset_i = 1'b1;
        #1;
        checks++;
        if ({pop_o, mac_clear_o, mac_en_o, out_valid_o, out_row_o, busy_o, done_o, err_o} !== 10'd0) begin
          errors++;
          $display("FAIL async_reset outputs got %b expected 0",
                   {pop_o, mac_clear_o, mac_en_o, out_valid_o, out_row_o, busy_o, done_o, err_o});
        end
      end
      @(posedge clk_i);
      #1;
    end
    @(negedge clk_i);
    reset_i = 1'b0;
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    checks++;
    if ({busy_o, out_valid_o, done_o} !== 3'b000) begin
      errors++; $display("FAIL async_after {busy,ov,done} got %b expected 000", {busy_o, out_valid_o, done_o});
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_back_to_back();
    int d1;
    int d2;
    fill_clean();
    run_op(2, 0, 1, 3, 0, d1);
    fill_clean();
    run_op(3, 1, 0, 0, 0, d2);
    checks++;
    if (d1 !== 7 || d2 !== 9) begin
      errors++; $display("FAIL back_to_back done cycles got %0d,%0d expected 7,9", d1, d2);
    end
  endtask

  task automatic test_random();
    int d;
    int n;
    for (int it = 0; it < 16; it++) begin
      fill_random();
      n = $urandom_range(8, 1);
      run_op(n, 0, 0, 0, 1, d);
    end
  endtask

  initial begin
    test_reset();
    test_n3_basic();
    test_n8_stall();
    test_unused_flag();
    test_backpressure();
    test_illegal_n();
    test_abort();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mxv_pop_sched.md
# mxv_pop_sched

Pop-side scheduler for the matrix-vector multiply datapath. After the push controller has loaded the eight matrix-row FIFOs and the vector FIFO, this block drives the common pop strobe column by column and gates the per-row MAC accumulators. It then presents the N row results one at a time over a valid/ready handshake. It sits between the FIFO bank and the result output path.

## Interface
- MAX_N, 8, maximum matrix order; number of row FIFOs.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- start  in  1  one-cycle request to begin an operation; sampled in IDLE only.
- N  in  4  matrix order; sampled with start; legal range 1..MAX_N.
- abort  in  1  synchronous abort; returns to IDLE on the next edge.
- fifo_empty  in  MAX_N  empty flags of row FIFOs; bit i is row i+1.
- vec_empty  in  1  empty flag of the vector FIFO.
- out_ready  in  1  downstream accepts the current result.
- pop  out  1  common pop to all row FIFOs and the vector FIFO.
- mac_clear  out  1  clears all row accumulators.
- mac_en  out  1  accumulators add the current FIFO outputs.
- out_valid  out  1  out_row identifies a finished result.
- out_row  out  3  row index 0..N-1 of the presented result.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last result is accepted.
- err  out  1  one-cycle pulse when start arrives with an illegal N.

## Operation
- States: IDLE, CLEAR, POP, DRAIN, OUT.
- IDLE: on start with 1 ≤ N ≤ MAX_N, latch N into n_r and go to CLEAR. On start with N = 0 or N > MAX_N, pulse err and stay in IDLE. start is ignored in every other state.
- CLEAR: mac_clear = 1 for exactly one cycle. Clear col to 0 and go to POP.
- POP: the gate is stall = vec_empty OR any fifo_empty[i] for i < n_r. Flags for i ≥ n_r are ignored.
  - pop = ~stall (combinational). No pop is issued during a stall, and the state is held.
  - On each pop, col increments.
  - A pop with col == n_r-1 moves the block to DRAIN.
- DRAIN: one cycle, so the last popped data is accumulated. Clear row to 0 and go to OUT.
- OUT: out_valid = 1 and out_row = row.
  - out_valid and out_row stay stable until out_ready is sampled high.
  - On acceptance, row increments.
  - Acceptance with row == n_r-1 returns the block to IDLE and pulses done.
- mac_en is a register holding the previous cycle's pop. This matches the 1-cycle FIFO read latency.
- abort has priority over all other events. The next state is IDLE and col, row, mac_en, done and err are cleared. pop is forced to 0 in the abort cycle. done is not pulsed.
- col and row are 3-bit counters and are compared against n_r-1. n_r is 4 bits. Neither counter wraps, because the state exits at n_r-1.
- N changing after start has no effect.

## Timing
- Reset values: pop=0, mac_clear=0, mac_en=0, out_valid=0, out_row=0, busy=0, done=0, err=0, state=IDLE.
- mac_clear, busy, out_valid and out_row are decoded from registers (Moore). done, err and mac_en are registered. pop is the only combinational output.
- start sampled at edge 0: CLEAR in cycle 1, first pop in cycle 2.
- With no stalls:
  - pops occur in cycles 2..N+1;
  - mac_en is high in cycles 3..N+2;
  - DRAIN is in cycle N+2;
  - OUT begins in cycle N+3.
- With out_ready held high, one row is accepted per cycle, rows 0..N-1 in cycles N+3..2N+2. done is high in cycle 2N+3, with busy=0 in the same cycle.
- Each stall cycle in POP delays everything that follows by one cycle. mac_en goes low one cycle after pop goes low.
- A new start is accepted in the cycle done is high, since the block is already in IDLE.

## Test plan
- N=3, all FIFOs non-empty, out_ready=1, start at cycle 0:
  - mac_clear in cycle 1;
  - pop in cycles 2-4;
  - mac_en in cycles 3-5;
  - out_row 0,1,2 in cycles 6-8;
  - done in cycle 9.
- N=8, vec_empty=1 during cycles 4-5: pop=0 in cycles 4-5 and the 8 pops end in cycle 11. mac_en never exceeds 8 cycles in total. done is in cycle 21.
- N=2 with fifo_empty[5]=1 held: no stalls occur, because the flag is for an unused row. Result is identical to the no-stall timing.
- N=4 in OUT with out_ready=0 for 3 cycles: out_valid=1 and out_row=0 hold steady, then rows advance one per ready cycle.
- start with N=0, then with N=9: err pulses once for each, busy stays 0, and pop never asserts.
- abort in cycle 3 of an N=5 run: IDLE in cycle 4, and pop/mac_en=0 from cycle 4 on with no done pulse. An async reset mid-OUT drives all outputs to 0 immediately.
